// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit multiplexed seven-segment scanner with double-buffered digits; optional blinking under SEG_BLINK_EN
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GHOST_CYC = 2
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 125
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SEG_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [3:0]  dig,
  output logic        frame_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   active, pending;
  logic          pending_valid, wrap, bnd, lit;
  logic [3:0]    en_eff;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign bnd  = wrap && idx == 2'd3;
  assign lit  = cnt >= CW'(GHOST_CYC) && en_eff[idx];
`ifdef SEG_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  assign en_eff = digit_en & ~(blink_mask & {4{blink_phase}});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bnd) begin
      frame_cnt   <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
      blink_phase <= frame_cnt == FW'(BLINK_FRAMES - 1) ? ~blink_phase : blink_phase;
    end
  end
`else
  assign en_eff = digit_en;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      idx           <= 2'd0;
      active        <= 16'h0000;
      pending       <= 16'h0000;
      pending_valid <= 1'b0;
      an            <= 4'b1111;
      dig           <= 4'hF;
      frame_start   <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      if (bnd) begin
        if (pending_valid) active <= pending;
        pending_valid <= 1'b0;
      end
      if (load) begin
        pending       <= digits_in;
        pending_valid <= 1'b1;
      end
      frame_start <= bnd;
      an          <= lit ? ~(4'b0001 << idx) : 4'b1111;
      dig         <= lit ? active[{idx, 2'b00} +: 4] : 4'hF;
    end
  end
endmodule
